conv2_window_buf: RTL and testbench
===================================

CONV2_WINDOW_BUF -- requirements
Module: conv2_window_buf

Interface
REQ-001 Parameter IMG_W, default 13, meaning pixels per input row.
REQ-002 Parameter IMG_H, default 13, meaning rows per input frame.
REQ-003 Parameter NUM_CH, default 8, meaning binary channels per input pixel.
REQ-004 Clock and reset SHALL be clk and rst_n: one clock, reset asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 valid_in  input  1  pixel_in is valid this cycle; the pixel is consumed unconditionally, with no backpressure.
REQ-008 pixel_in  input  NUM_CH  one binarized pixel, bit ch = channel ch, in raster order.
REQ-009 pixel_windows  output  9*NUM_CH  registered 3x3xNUM_CH window for the conv2 calculator.
REQ-010 valid_out_buf  output  1  pixel_windows holds a new complete window; one-cycle pulse per window.
REQ-011 frame_done  output  1  one-cycle pulse on the cycle the last window of a frame is presented.

Function
REQ-012 Internal counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance only on valid_in cycles; col wraps to 0 and increments row; row wraps to 0 after IMG_H-1.
REQ-013 Two line stores line0 and line1 (IMG_W x NUM_CH each) SHALL hold rows r-2 and r-1 at column col.
REQ-014 On valid_in, the column {line0[col], line1[col], pixel_in} SHALL shift into the window's right column while the older columns shift left; line0[col]<=line1[col] and line1[col]<=pixel_in in the same cycle.
REQ-015 Window bit packing SHALL be pixel_windows[ch*9 + r*3 + c], with r=0 top (oldest row), c=0 left (oldest column), and r,c in 0..2.
REQ-016 valid_out_buf SHALL assert exactly 1 cycle after a valid_in whose pre-increment row>=2 and col>=2 (valid padding only); it SHALL be 0 otherwise, including during gaps.
REQ-017 pixel_windows SHALL update only when valid_out_buf asserts and SHALL hold its value otherwise; no zeroing between windows.
REQ-018 Windows per frame SHALL equal (IMG_W-2)*(IMG_H-2), which is 121 at the default parameters.
REQ-019 frame_done SHALL assert together with valid_out_buf for the window produced by input (row=IMG_H-1, col=IMG_W-1).
REQ-020 At a frame boundary the next frame SHALL start at row 0; windows never straddle rows or frames because the row>=2 and col>=2 gating applies.
REQ-021 Idle cycles (valid_in=0) anywhere in a frame SHALL NOT change counters, stores, window or outputs beyond pulse deassertion.

Reset
REQ-022 Asserting rst_n low SHALL immediately clear row, col, pixel_windows, valid_out_buf and frame_done to 0.
REQ-023 Line-store contents need not be reset; the gating in REQ-016 SHALL guarantee that stale data never reaches a valid window.
REQ-024 Reset mid-frame SHALL abandon the frame; the first valid_in after release SHALL be treated as row 0, col 0.

Structure
REQ-025 A shared package conv2_pkg SHALL hold IMG_W, IMG_H, NUM_CH and WINDOW_SIZE=9*NUM_CH, which is also used by the conv2 calculator.
REQ-026 One sub-module, conv2_line_mem, SHALL implement a single IMG_W x NUM_CH line store with same-cycle read-then-write; it SHALL be instantiated twice.
REQ-027 Output registers SHALL feed the combinational conv2 calculator directly; the total pixel-to-window latency SHALL be 1 clock.

Verification
REQ-028 Full 13x13 frame with pixel_in = ch-bit pattern (row+col+ch)%2, continuous valid_in -> exactly 121 valid_out_buf pulses, and every window matches the golden model per REQ-015.
REQ-029 Window check: pixel (r,c) channel 0 = 1 only at (2,2), all else 0 -> pixel_windows[8]=1 in the first window (r=2,c=2), and bit 0 set in the window at output (4,4).
REQ-030 Same frame with valid_in randomly low 50% of cycles -> identical window sequence to REQ-028, and no pulses during gaps.
REQ-031 Two back-to-back frames -> frame_done pulses twice, each coincident with the 121st window; the second frame's first window is at input (2,2) and contains no frame-1 data.
REQ-032 rst_n low at input (7,5), then a full frame -> outputs 0 during reset, followed by 121 correct windows.
REQ-033 First two rows plus input (2,0) and (2,1) -> valid_out_buf stays 0 throughout.

Source files
------------

// File: rtl/conv2_pkg.sv
// Shared sizing for the conv2 window buffer and the conv2 calculator.
// Holds default image geometry, channel count and the flat window width.
package conv2_pkg;

   localparam int IMG_W       = 13;
   localparam int IMG_H       = 13;
   localparam int NUM_CH      = 8;
   localparam int WINDOW_SIZE = 9 * NUM_CH;

   // Flat bit position of window pixel (r,c) on channel ch; r=0 top row, c=0 left column.
   function automatic int win_bit(input int ch, input int r, input int c);
      return ch * 9 + r * 3 + c;
   endfunction

endpackage

// File: rtl/conv2_window_buf_if.sv
// Pixel stream in, 3x3 window out, between the binarizer, the window buffer
// and the conv2 calculator.
interface conv2_window_buf_if #(
   parameter int NUM_CH = conv2_pkg::NUM_CH
);

   logic                  valid_in;
   logic [NUM_CH-1:0]     pixel_in;
   logic [9*NUM_CH-1:0]   pixel_windows;
   logic                  valid_out_buf;
   logic                  frame_done;

   modport master (
      output valid_in,
      output pixel_in,
      input  pixel_windows,
      input  valid_out_buf,
      input  frame_done
   );

   modport slave (
      input  valid_in,
      input  pixel_in,
      output pixel_windows,
      output valid_out_buf,
      output frame_done
   );

endinterface

// File: rtl/conv2_line_mem.sv
// One image row of NUM_CH-bit pixels; combinational read and clocked write
// at the same address give read-then-write within a cycle. Contents are not reset.
module conv2_line_mem #(
   parameter int IMG_W  = 13,
   parameter int NUM_CH = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [NUM_CH-1:0] wdata,
   output logic [NUM_CH-1:0] rdata
);

   logic [NUM_CH-1:0] mem_q [IMG_W];

   assign rdata = mem_q[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv2_window_buf.sv
// Raster-scan 3x3xNUM_CH window generator with two line stores; presents one
// registered window per valid interior pixel, one clock after that pixel.
module conv2_window_buf #(
   parameter int IMG_W  = conv2_pkg::IMG_W,
   parameter int IMG_H  = conv2_pkg::IMG_H,
   parameter int NUM_CH = conv2_pkg::NUM_CH
) (
   input  logic               clk,
   input  logic               rst_n,
   conv2_window_buf_if.slave  bus
);

   import conv2_pkg::*;

   localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int WIN_BITS = 9 * NUM_CH;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]               col_q, col_d;
   logic [RW-1:0]               row_q, row_d;
   logic [NUM_CH-1:0]           line0_rd, line1_rd;
   logic [2:0][2:0][NUM_CH-1:0] win_q, win_d;
   logic [WIN_BITS-1:0]         win_flat;
   logic [WIN_BITS-1:0]         pix_win_q, pix_win_d;
   logic                        valid_out_q, valid_out_d;
   logic                        frame_done_q, frame_done_d;
   logic                        win_ready;

   // line0 holds row r-2, line1 row r-1; line0 is refilled from line1's old value.
   conv2_line_mem #(.IMG_W(IMG_W), .NUM_CH(NUM_CH), .ADDR_W(CW)) u_line0 (
      .clk   (clk),
      .we    (bus.valid_in),
      .addr  (col_q),
      .wdata (line1_rd),
      .rdata (line0_rd)
   );

   conv2_line_mem #(.IMG_W(IMG_W), .NUM_CH(NUM_CH), .ADDR_W(CW)) u_line1 (
      .clk   (clk),
      .we    (bus.valid_in),
      .addr  (col_q),
      .wdata (bus.pixel_in),
      .rdata (line1_rd)
   );

   assign win_ready = bus.valid_in && (row_q >= RW'(2)) && (col_q >= CW'(2));

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      pix_win_d    = pix_win_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      win_flat     = '0;

      if (bus.valid_in) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = line0_rd;
         win_d[1][2] = line1_rd;
         win_d[2][2] = bus.pixel_in;

         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_flat[win_bit(ch, r, c)] = win_d[r][c][ch];
            end
         end
      end

      // Edge-of-image positions shift the window but never publish it.
      if (win_ready) begin
         pix_win_d    = win_flat;
         valid_out_d  = 1'b1;
         frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         pix_win_q    <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         pix_win_q    <= pix_win_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.pixel_windows = pix_win_q;
   assign bus.valid_out_buf = valid_out_q;
   assign bus.frame_done    = frame_done_q;

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: an image-array reference model checked
// every cycle, plus hand-computed window literals and pulse counts.
module tb_conv2_window_buf;

   localparam int W  = 13;
   localparam int H  = 13;
   localparam int NC = 8;
   localparam int WS = 9 * NC;

   logic clk;
   logic rst_n;

   conv2_window_buf_if #(.NUM_CH(NC)) bus ();

   conv2_window_buf #(.IMG_W(W), .IMG_H(H), .NUM_CH(NC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [NC-1:0] img [H][W];
   logic          exp_v;
   logic          exp_fd;
   logic [WS-1:0] exp_win;

   int            win_cnt;
   int            fd_cnt;
   int            fd_at [$];
   logic [WS-1:0] first_win;
   logic [WS-1:0] win25;

   function automatic logic [NC-1:0] pat(input int r, input int c);
      logic [NC-1:0] p;
      for (int ch = 0; ch < NC; ch++) p[ch] = (((r + c + ch) % 2) != 0);
      return p;
   endfunction

   // Window for input (r,c): image rows r-2..r, columns c-2..c of the current frame.
   function automatic logic [WS-1:0] model_win(input int r, input int c);
      logic [WS-1:0] w;
      w = '0;
      for (int ch = 0; ch < NC; ch++)
         for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
               w[ch*9 + rr*3 + cc] = img[r-2+rr][c-2+cc][ch];
      return w;
   endfunction

   task automatic check_vec(input string name, input logic [WS-1:0] got, input logic [WS-1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic compare_cycle();
      checks++;
      if (bus.valid_out_buf !== exp_v) begin
         failures++;
         $display("FAIL valid_out_buf t=%0t got=%b want=%b", $time, bus.valid_out_buf, exp_v);
      end
      checks++;
      if (bus.frame_done !== exp_fd) begin
         failures++;
         $display("FAIL frame_done t=%0t got=%b want=%b", $time, bus.frame_done, exp_fd);
      end
      checks++;
      if (bus.pixel_windows !== exp_win) begin
         failures++;
         $display("FAIL pixel_windows t=%0t got=%h want=%h", $time, bus.pixel_windows, exp_win);
      end
      if (bus.valid_out_buf === 1'b1) begin
         win_cnt++;
         if (win_cnt == 1)  first_win = bus.pixel_windows;
         if (win_cnt == 25) win25     = bus.pixel_windows;
      end
      if (bus.frame_done === 1'b1) begin
         fd_cnt++;
         fd_at.push_back(win_cnt);
      end
   endtask

   // Present one input for one clock and advance the model at that edge.
   task automatic drive(input bit v, input logic [NC-1:0] p, input int r, input int c);
      bus.valid_in = v;
      bus.pixel_in = p;
      if (v) img[r][c] = p;
      @(posedge clk);
      if (rst_n && v && r >= 2 && c >= 2) begin
         exp_v   = 1'b1;
         exp_fd  = (r == H-1) && (c == W-1);
         exp_win = model_win(r, c);
      end else begin
         exp_v  = 1'b0;
         exp_fd = 1'b0;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, NC'($urandom), 0, 0);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      exp_v   = 1'b0;
      exp_fd  = 1'b0;
      exp_win = '0;
      idle(3);
      rst_n = 1'b1;
   endtask

   // mode 0: parity pattern, 1: single pixel at (2,2) ch0, 2: random. stop_at>=0 ends before that input.
   task automatic send_frame(input int mode, input bit gaps, input int stop_r, input int stop_c);
      logic [NC-1:0] p;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r == stop_r && c == stop_c) return;
            case (mode)
               0:       p = pat(r, c);
               1:       p = (r == 2 && c == 2) ? NC'(1) : '0;
               default: p = NC'($urandom);
            endcase
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            drive(1'b1, p, r, c);
         end
      end
   endtask

   task automatic start_count();
      win_cnt = 0;
      fd_cnt  = 0;
      fd_at.delete();
      first_win = '0;
      win25     = '0;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.valid_in = 1'b0;
      bus.pixel_in = '0;
      exp_v        = 1'b0;
      exp_fd       = 1'b0;
      exp_win      = '0;
      start_count();

      fork
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none

      idle(3);
      check_vec("reset_window", bus.pixel_windows, '0);
      rst_n = 1'b1;

      // Rows 0..1 plus (2,0),(2,1): still at the image edge, no window.
      start_count();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < W; c++) drive(1'b1, pat(r, c), r, c);
      drive(1'b1, pat(2, 0), 2, 0);
      drive(1'b1, pat(2, 1), 2, 1);
      idle(4);
      check_int("edge_no_window", win_cnt, 0);
      do_reset();

      // Continuous parity frame.
      start_count();
      send_frame(0, 1'b0, -1, -1);
      idle(3);
      check_int("frame_windows", win_cnt, 121);
      check_int("frame_done_cnt", fd_cnt, 1);
      check_vec("first_win_ch0", WS'(first_win[8:0]), WS'(9'h0AA));
      check_vec("first_win_ch1", WS'(first_win[17:9]), WS'(9'h155));

      // Single set pixel at (2,2) on channel 0.
      start_count();
      send_frame(1, 1'b0, -1, -1);
      idle(2);
      check_vec("single_first_win", first_win, WS'(72'h100));
      check_vec("single_win_4_4", win25, WS'(72'h1));

      // Parity frame with random idle gaps.
      start_count();
      send_frame(0, 1'b1, -1, -1);
      idle(3);
      check_int("gap_frame_windows", win_cnt, 121);
      check_vec("gap_first_win_ch0", WS'(first_win[8:0]), WS'(9'h0AA));

      // Two back-to-back frames, second with unrelated random data.
      start_count();
      send_frame(0, 1'b0, -1, -1);
      send_frame(2, 1'b0, -1, -1);
      idle(3);
      check_int("two_frames_windows", win_cnt, 242);
      check_int("two_frames_done", fd_cnt, 2);
      check_int("frame_done_1_at", (fd_at.size() > 0) ? fd_at[0] : -1, 121);
      check_int("frame_done_2_at", (fd_at.size() > 1) ? fd_at[1] : -1, 242);

      // Reset in place of input (7,5), then a full random frame.
      send_frame(0, 1'b0, 7, 5);
      do_reset();
      check_vec("midreset_window", bus.pixel_windows, '0);
      start_count();
      send_frame(2, 1'b1, -1, -1);
      idle(3);
      check_int("after_reset_windows", win_cnt, 121);
      check_int("after_reset_done", fd_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
